// File: rtl/alu_byte_sequencer_pkg.sv
// alu_seq_pkg: shared FSM state type, slice width and ALU op encodings
package alu_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int SLICE_W = 8;
    localparam logic [3:0] ALU_OP_AND = 4'b0000;
    localparam logic [3:0] ALU_OP_OR  = 4'b0001;
    localparam logic [3:0] ALU_OP_ADD = 4'b0010;
    localparam logic [3:0] ALU_OP_SUB = 4'b0110;
endpackage

// File: rtl/alu_byte_sequencer_if.sv
// alu_byte_sequencer_if: request/response handshake bundle for the byte sequencer
//   master: execute stage (drives in_valid, a, b, carry_in, ALU_op, out_ready)
//   slave:  sequencer (drives in_ready, out_valid, result, carry_out, zero)
interface alu_byte_sequencer_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic [3:0]       ALU_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero;
    modport master (
        output in_valid, a, b, carry_in, ALU_op, out_ready,
        input  in_ready, out_valid, result, carry_out, zero
    );
    modport slave (
        input  in_valid, a, b, carry_in, ALU_op, out_ready,
        output in_ready, out_valid, result, carry_out, zero
    );
endinterface

// File: rtl/alu_byte_sequencer_slice.sv
// eightbit_ALU: 8-bit ALU slice (AND, OR, ADD, SUB) with carry in/out
//   a, b, carry_in, ALU_op -> result, carry_out
//   Logic ops report carry_out=0; SUB expects carry_in=1 (two's complement).
module eightbit_ALU
    import alu_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               carry_in,
    input  logic [3:0]         ALU_op,
    output logic [SLICE_W-1:0] result,
    output logic               carry_out
);
    logic [SLICE_W:0] sum;
    always_comb begin
        sum = {1'b0, a} + {1'b0, (ALU_op == ALU_OP_SUB) ? ~b : b} + {{SLICE_W{1'b0}}, carry_in};
        result = (ALU_op == ALU_OP_AND) ? (a & b) : (ALU_op == ALU_OP_OR) ? (a | b) : sum[SLICE_W-1:0];
        carry_out = (ALU_op == ALU_OP_ADD || ALU_op == ALU_OP_SUB) && sum[SLICE_W];
    end
endmodule

// File: rtl/alu_byte_sequencer.sv
// alu_byte_sequencer: runs one WIDTH-bit ALU op through an 8-bit slice, one byte per cycle
//   clk, reset (sync, active-high), bus (alu_byte_sequencer_if.slave), busy (state != IDLE)
//   Optional macro ALU_SEQ_BACK2BACK_EN: accept a new request in the same cycle a result is taken.
module alu_byte_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic                clk,
    input  logic                reset,
    alu_byte_sequencer_if.slave bus,
    output logic                busy
);
    localparam int NB = WIDTH / SLICE_W;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NB - 1);

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]         op_q, op_d;
    logic               cy_q, cy_d, co_q, co_d, zero_q, zero_d;
    logic               start;
    logic [SLICE_W-1:0] slice_r;
    logic               slice_co;

    eightbit_ALU u_slice (
        .a        (a_q[idx_q*SLICE_W +: SLICE_W]),
        .b        (b_q[idx_q*SLICE_W +: SLICE_W]),
        .carry_in (cy_q),
        .ALU_op   (op_q),
        .result   (slice_r),
        .carry_out(slice_co)
    );

`ifdef ALU_SEQ_BACK2BACK_EN
    assign bus.in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
`else
    assign bus.in_ready = (state_q == IDLE);
`endif
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.carry_out = co_q;
    assign bus.zero      = zero_q;
    assign busy          = (state_q != IDLE);
    assign start         = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cy_d    = cy_q;
        res_d   = res_q;
        co_d    = co_q;
        zero_d  = zero_q;
        if (state_q == RUN) begin
            res_d[idx_q*SLICE_W +: SLICE_W] = slice_r;
            cy_d  = slice_co;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST) begin
                state_d = DONE;
                co_d    = slice_co;
                zero_d  = (res_d == '0);
            end
        end
        if (state_q == DONE && bus.out_ready)
            state_d = IDLE;
        // an accept (from IDLE, or from DONE during handoff) overrides the return to IDLE
        if (start) begin
            state_d = RUN;
            idx_d   = '0;
            a_d     = bus.a;
            b_d     = bus.b;
            op_d    = bus.ALU_op;
            cy_d    = bus.carry_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cy_q    <= 1'b0;
            res_q   <= '0;
            co_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cy_q    <= cy_d;
            res_q   <= res_d;
            co_q    <= co_d;
            zero_q  <= zero_d;
        end
    end
endmodule

// File: tb/tb_alu_byte_sequencer.sv
// tb_alu_byte_sequencer: scoreboard-based checks of the byte-serial ALU sequencer
module tb_alu_byte_sequencer;
    import alu_seq_pkg::*;
    localparam int W = 32;
    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         z;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    alu_byte_sequencer_if #(.WIDTH(W)) bus ();
    alu_byte_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus), .busy(busy));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached, required finish earlier");
        $fatal(1, "timeout");
    end

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic [3:0] op);
        logic [W:0] s;
        exp_t e;
        s = {1'b0, x} + {1'b0, (op == ALU_OP_SUB) ? ~y : y} + {{W{1'b0}}, ci};
        e.r = (op == ALU_OP_AND) ? (x & y) : (op == ALU_OP_OR) ? (x | y) : s[W-1:0];
        e.c = (op == ALU_OP_ADD || op == ALU_OP_SUB) && s[W];
        e.z = (e.r == '0);
        return e;
    endfunction

    // called at a negedge; returns at the negedge right after the accept edge
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci, input logic [3:0] top);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL send_ready: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.a = ta;
        bus.b = tb;
        bus.carry_in = tci;
        bus.ALU_op = top;
        sb.push_back(model(ta, tb, tci, top));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.carry_in = 1'($urandom);
        bus.ALU_op = 4'($urandom);
    endtask

    // cycles from the accept edge until out_valid is seen; -1 if it never rises
    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            bus.a = $urandom;
            bus.b = $urandom;
        end
        if (bus.out_valid !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.carry_in = 1'b0;
        bus.ALU_op = ALU_OP_ADD;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: out_valid=%b busy=%b required 0 0", bus.out_valid, busy);
        end
        n_cmp++;
        if (bus.result !== '0 || bus.carry_out !== 1'b0 || bus.zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: result=%h carry=%b zero=%b required 0 0 0", bus.result, bus.carry_out, bus.zero);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_ops();
        logic [W-1:0] ta[5] = '{32'h000000FF, 32'hFFFFFFFF, 32'h12345678, 32'hF0F0F0F0, 32'h0F0F0000};
        logic [W-1:0] tb[5] = '{32'h00000001, 32'h00000001, 32'h12345678, 32'h0FF00FF0, 32'h00F000F1};
        logic         tc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0]   to[5] = '{ALU_OP_ADD, ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR};
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            int lat;
            send(ta[i], tb[i], tc[i], to[i]);
            wait_valid(lat);
            e = sb.pop_front();
            n_cmp++;
            if (lat != 4) begin
                n_err++;
                $display("FAIL op%0d_latency: %0d cycles required 4", i, lat);
            end
            n_cmp++;
            if (bus.result !== e.r) begin
                n_err++;
                $display("FAIL op%0d_result: %h required %h", i, bus.result, e.r);
            end
            n_cmp++;
            if (bus.carry_out !== e.c || bus.zero !== e.z) begin
                n_err++;
                $display("FAIL op%0d_flags: carry=%b zero=%b required %b %b", i, bus.carry_out, bus.zero, e.c, e.z);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_hold();
        exp_t e;
        int lat;
        send(32'h11111111, 32'h22222222, 1'b0, ALU_OP_ADD);
        wait_valid(lat);
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== e.r || bus.carry_out !== e.c || bus.zero !== e.z) begin
                n_err++;
                $display("FAIL hold_c%0d: valid=%b in_ready=%b result=%h c=%b z=%b required 1 0 %h %b %b",
                         k, bus.out_valid, bus.in_ready, bus.result, bus.carry_out, bus.zero, e.r, e.c, e.z);
            end
            @(negedge clk);
            bus.a = $urandom;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL hold_release: out_valid=%b busy=%b required 0 0", bus.out_valid, busy);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int lat;
        int seen = 0;
        send(32'h00000001, 32'h00000001, 1'b0, ALU_OP_ADD);
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_state: busy=%b in_ready=%b out_valid=%b required 0 1 0", busy, bus.in_ready, bus.out_valid);
        end
        n_cmp++;
        if (bus.result !== '0 || bus.carry_out !== 1'b0 || bus.zero !== 1'b0) begin
            n_err++;
            $display("FAIL abort_outputs: result=%h carry=%b zero=%b required 0 0 0", bus.result, bus.carry_out, bus.zero);
        end
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL abort_no_valid: out_valid seen %0d cycles required 0", seen);
        end
        send(32'd3, 32'd4, 1'b0, ALU_OP_ADD);
        wait_valid(lat);
        e = sb.pop_front();
        n_cmp++;
        if (lat != 4 || bus.result !== e.r || e.r !== 32'd7) begin
            n_err++;
            $display("FAIL after_abort_add: result=%h lat=%0d required %h 4", bus.result, lat, e.r);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] xa[2] = '{32'd5, 32'd100};
        logic [W-1:0] xb[2] = '{32'd6, 32'd200};
        int vt[$];
        int k = 0;
        int t = 0;
        int gap;
        logic acc;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.a = xa[0];
        bus.b = xb[0];
        bus.carry_in = 1'b0;
        bus.ALU_op = ALU_OP_ADD;
        while (vt.size() < 2 && t < 40) begin
            if (bus.out_valid === 1'b1) begin
                exp_t e;
                vt.push_back(t);
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                n_cmp++;
                if (bus.result !== e.r || bus.carry_out !== e.c || bus.zero !== e.z) begin
                    n_err++;
                    $display("FAIL b2b_result%0d: %h required %h", vt.size(), bus.result, e.r);
                end
            end
            acc = bus.in_valid && (bus.in_ready === 1'b1);
            @(posedge clk);
            #1;
            if (acc) begin
                sb.push_back(model(bus.a, bus.b, bus.carry_in, bus.ALU_op));
                k++;
                if (k < 2) begin
                    bus.a = xa[k];
                    bus.b = xb[k];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge clk);
            t++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        gap = (vt.size() == 2) ? vt[1] - vt[0] : -1;
`ifdef ALU_SEQ_BACK2BACK_EN
        n_cmp++;
        if (gap != 5) begin
            n_err++;
            $display("FAIL b2b_gap: %0d cycles required 5", gap);
        end
`else
        n_cmp++;
        if (gap != 6) begin
            n_err++;
            $display("FAIL b2b_gap: %0d cycles required 6", gap);
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ops();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
